// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Data-memory port between the MEM stage (master) and the memory responder
// (slave). Carries two independent valid/ready handshakes:
//   request  : req_valid/req_ready, req_we, req_addr, req_wdata, req_size,
//              req_unsigned       (master -> slave, ready slave -> master)
//   response : rsp_valid/rsp_ready, rsp_rdata, rsp_err
//              (slave -> master, ready master -> slave)
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Stallable data-memory slave for the MEM stage. Accepts one load/store at a
// time, waits WAIT_CYCLES extra cycles, then performs a byte/half/word access
// to an internal word-organised RAM and returns the (extended) load data or an
// error flag.
// Parameters:
//   DEPTH_WORDS : RAM depth in 32-bit words (word index = req_addr[31:2])
//   WAIT_CYCLES : extra wait states per access, 0..15
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : dmem_responder_if slave modport (request + response handshakes)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_V   = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e         state_r;
    logic [3:0]     cnt_r;
    logic           we_r;
    logic [31:0]    addr_r;
    logic [31:0]    wdata_r;
    logic [1:0]     size_r;
    logic           unsigned_r;
    logic           req_ready_r;
    logic           rsp_valid_r;
    logic [31:0]    rsp_rdata_r;
    logic           rsp_err_r;

    logic [31:0]    mem_r [DEPTH_WORDS];

    logic [AW-1:0]  idx_s;
    logic           err_s;
    logic [31:0]    rd_word_s;
    logic [31:0]    load_s;
    logic [31:0]    merged_s;
    logic           mem_we_s;

    // Misalignment, illegal size or word index beyond the RAM.
    function automatic logic req_err(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = addr[0];
            2'b10:   e = (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= DEPTH_V) begin
            e = 1'b1;
        end else begin
            e = e;
        end
        return e;
    endfunction

    // Pick the addressed lane out of a RAM word and sign/zero extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte lanes of the old word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [3:0]  be;
        logic [31:0] rep;
        logic [31:0] res;
        case (size)
            2'b00: begin
                be  = 4'b0001 << lane;
                rep = {4{data[7:0]}};
            end
            2'b01: begin
                be  = lane[1] ? 4'b1100 : 4'b0011;
                rep = {2{data[15:0]}};
            end
            2'b10: begin
                be  = 4'b1111;
                rep = data;
            end
            default: begin
                be  = 4'b0000;
                rep = 32'h0000_0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? rep[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return res;
    endfunction

    assign idx_s = addr_r[AW+1:2];

    // Decode the captured request and build the access-edge data.
    always_comb begin
        err_s     = req_err(size_r, addr_r);
        rd_word_s = mem_r[idx_s];
        load_s    = load_extract(rd_word_s, addr_r[1:0], size_r, unsigned_r);
        merged_s  = store_merge(rd_word_s, wdata_r, addr_r[1:0], size_r);
        // rst gates the write so a reset held across the access edge drops the store.
        if ((state_r == ST_BUSY) && (cnt_r == 4'd0) && we_r && !err_s && rst) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Request/wait/response sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            size_r      <= 2'b00;
            unsigned_r  <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        we_r        <= bus.req_we;
                        addr_r      <= bus.req_addr;
                        wdata_r     <= bus.req_wdata;
                        size_r      <= bus.req_size;
                        unsigned_r  <= bus.req_unsigned;
                        cnt_r       <= WAIT_INIT;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_rdata_r <= (err_s || we_r) ? 32'h0000_0000 : load_s;
                        rsp_err_r   <= err_s;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // One outstanding request: req_ready only returns after the handshake.
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. The main instance (WAIT_CYCLES=1) is
// driven through a request task that queues the expected response; a separate
// monitor pops the queue on every response handshake. Two extra instances
// (WAIT_CYCLES=0 and 15) are used for latency measurement.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk;
    logic rst;

    dmem_responder_if b1 ();
    dmem_responder_if b0 ();
    dmem_responder_if b15 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1))  u_dut (.clk(clk), .rst(rst), .bus(b1));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0))  u_w0  (.clk(clk), .rst(rst), .bus(b0));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(15)) u_w15 (.clk(clk), .rst(rst), .bus(b15));

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q [$];
    int   n_pass  = 0;
    int   n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && b1.rsp_valid && b1.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", b1.rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, b1.rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Issue one request on the main instance and check accept-to-valid latency.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit wait_done);
        int n;
        @(negedge clk);
        b1.req_valid    = 1'b1;
        b1.req_we       = we;
        b1.req_addr     = addr;
        b1.req_wdata    = wdata;
        b1.req_size     = size;
        b1.req_unsigned = uns;
        n = 0;
        while (!b1.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b1.req_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end
        exp_q.push_back({exp_rdata, exp_err});
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        n = 0;
        while (!b1.rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_w1", n, 32'd2);
        if (wait_done) begin
            n = 0;
            while (b1.rsp_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (b1.rsp_valid) begin
                chk("rsp_drain_timeout", 32'd1, 32'd0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b0;
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h0000_0010;
        b1.req_wdata = 32'h1111_1111; b1.req_size = 2'b10; b1.req_unsigned = 1'b0;
        b1.rsp_ready = 1'b1;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 32'h0;
        b0.req_wdata = 32'h0; b0.req_size = 2'b10; b0.req_unsigned = 1'b0;
        b0.rsp_ready = 1'b1;
        b15.req_valid = 1'b0; b15.req_we = 1'b0; b15.req_addr = 32'h0;
        b15.req_wdata = 32'h0; b15.req_size = 2'b10; b15.req_unsigned = 1'b0;
        b15.rsp_ready = 1'b1;

        // Reset: request held during reset must be ignored.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, b1.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, b1.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", b1.rsp_rdata, 32'h0);
        chk("rst_rsp_err",   {31'd0, b1.rsp_err}, 32'd0);
        @(negedge clk);
        b1.req_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, b1.rsp_valid}, 32'd0);

        // Latency at WAIT_CYCLES = 0 and 15 (stores return rdata 0).
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_wdata = 32'h0000_0001;
        @(posedge clk);
        #1;
        b0.req_valid = 1'b0;
        n = 0;
        while (!b0.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency_w0", n, 32'd1);
        chk("w0_rdata", b0.rsp_rdata, 32'h0);
        @(negedge clk);
        b15.req_valid = 1'b1; b15.req_we = 1'b1; b15.req_wdata = 32'h0000_0002;
        @(posedge clk);
        #1;
        b15.req_valid = 1'b0;
        n = 0;
        while (!b15.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency_w15", n, 32'd16);
        chk("w15_err", {31'd0, b15.rsp_err}, 32'd0);

        // Word store/load.
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, 32'h10, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Byte/half lanes; upper store-data bits must be ignored.
        issue(1'b1, 32'h20, 32'h0000_0000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h22, 32'hABCD_EF80, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h20, 32'h9999_1234, 2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0080_1234, 1'b0, 1'b1);
        issue(1'b0, 32'h22, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1);
        issue(1'b0, 32'h22, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 2'b01, 1'b0, 32'h0000_1234, 1'b0, 1'b1);
        issue(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'h0000_0012, 1'b0, 1'b1);
        issue(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
        issue(1'b1, 32'h28, 32'h0000_8001, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h28, 32'h0, 2'b01, 1'b0, 32'hFFFF_8001, 1'b0, 1'b1);

        // Errors.
        issue(1'b0, 32'h21,   32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h22,   32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h20,   32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h24, 32'h1122_3344, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h26, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(1'b1, 32'h1000, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 32'h1122_3344, 1'b0, 1'b1);

        // Last word in range.
        issue(1'b1, 32'hFFC, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1);

        // Backpressure: response held 5 cycles while a second request waits.
        b1.rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h10;
        b1.req_wdata = 32'h5555_5555; b1.req_size = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", {31'd0, b1.rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", b1.rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_rsp_err",   {31'd0, b1.rsp_err}, 32'd0);
            chk("bp_req_ready", {31'd0, b1.req_ready}, 32'd0);
        end
        b1.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_after_hs_ready", {31'd0, b1.req_ready}, 32'd1);
        chk("bp_after_hs_valid", {31'd0, b1.rsp_valid}, 32'd0);
        b1.req_valid = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Reset during BUSY, one edge before the store would land.
        issue(1'b1, 32'h30, 32'h1357_2468, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h30;
        b1.req_wdata = 32'hAAAA_5555; b1.req_size = 2'b10;
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, b1.req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, b1.rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", b1.rsp_rdata, 32'h0);
        chk("midrst_rsp_err",   {31'd0, b1.rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 32'h1357_2468, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
